// File: rtl/avfcl_pkg.sv
// Shared constants and types for the AVF-estimation blocks that consume
// store-queue duration samples.
package avfcl_pkg;

  localparam int DURATION_WIDTH = 10;
  localparam int WIN_LOG2       = 4;
  localparam int WIN_SIZE       = 1 << WIN_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } avg_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = 1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/sq_dur_avg.sv
// Windowed average / max of store-queue residency samples; publishes one
// result set every 2^LOG2_WIN accepted samples.
module sq_dur_avg
  import avfcl_pkg::*;
#(
  parameter int DUR_W    = DURATION_WIDTH,
  parameter int LOG2_WIN = WIN_LOG2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             dur_valid,
  input  logic [DUR_W-1:0] dur_dp,
  input  logic [DUR_W-1:0] dur_exec,
  output logic [DUR_W-1:0] avg_dp,
  output logic [DUR_W-1:0] avg_exec,
  output logic [DUR_W-1:0] max_exec,
  output logic             out_valid,
  output logic [15:0]      win_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int SUM_W = DUR_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_ONE  = 1;
  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

  // Sums are sized so a full window cannot overflow; dividing is a plain slice.
  function automatic logic [DUR_W-1:0] win_avg(input logic [SUM_W-1:0] sum);
    return sum[SUM_W-1:LOG2_WIN];
  endfunction

  avg_state_t          state, state_next;
  logic [SUM_W-1:0]    sum_dp, sum_exec;
  logic [SUM_W-1:0]    sum_dp_next, sum_exec_next;
  logic [DUR_W-1:0]    max_run, max_next;
  logic [LOG2_WIN-1:0] cnt;
  logic                live, accept, reject, last;

  assign live          = (state != IDLE) && dur_valid && enable && !clear;
  assign accept        = live && (dur_dp <= dur_exec);
  assign reject        = live && (dur_dp > dur_exec);
  assign last          = accept && (cnt == CNT_LAST);
  assign sum_dp_next   = sum_dp + SUM_W'(dur_dp);
  assign sum_exec_next = sum_exec + SUM_W'(dur_exec);
  assign max_next      = (dur_exec >= max_run) ? dur_exec : max_run;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = ACCUM;
      ACCUM: begin
        if (!enable)   state_next = IDLE;
        else if (last) state_next = PUBLISH;
      end
      PUBLISH: begin
        if (last)        state_next = PUBLISH;
        else if (enable) state_next = ACCUM;
        else             state_next = IDLE;
      end
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Window accumulation: a publishing sample also restarts the window, so a
  // sample accepted in the PUBLISH cycle lands in the fresh window.
  always_ff @(posedge clk) begin
    if (!reset || clear || !enable || last) begin
      sum_dp   <= '0;
      sum_exec <= '0;
      max_run  <= '0;
      cnt      <= '0;
    end else if (accept) begin
      sum_dp   <= sum_dp_next;
      sum_exec <= sum_exec_next;
      max_run  <= max_next;
      cnt      <= cnt + CNT_ONE;
    end
  end

  // Published results include the final sample of the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      avg_dp    <= '0;
      avg_exec  <= '0;
      max_exec  <= '0;
      out_valid <= 1'b0;
      win_count <= '0;
    end else begin
      out_valid <= last;
      if (last) begin
        avg_dp    <= win_avg(sum_dp_next);
        avg_exec  <= win_avg(sum_exec_next);
        max_exec  <= max_next;
        win_count <= win_count + 16'd1;
      end
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (reject),
    .count(err_count)
  );

endmodule

// File: doc/sq_dur_avg.md
Name: sq_dur_avg

Overview:
Downstream consumer of the store-queue duration monitor. It accepts completed SQ-residency samples (dispatch-to-exec and dispatch-to-retire durations, 10-bit, 16-cycle units) and accumulates them over a power-of-two window. At the end of each window it publishes window averages and the window maximum to the AVF-estimation logic.

Parameters:
DUR_W, 10, duration sample width; equals the shared DURATION_WIDTH constant.
LOG2_WIN, 4, log2 of window size; window = 16 accepted samples.
ERR_W, 8, width of the saturating rejected-sample counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  accumulation enable; level
clear  in  1  single-cycle pulse; discards the partial window
dur_valid  in  1  single-cycle pulse; a completed sample is present
dur_dp  in  DUR_W  dispatch-to-exec duration
dur_exec  in  DUR_W  dispatch-to-retire duration
avg_dp  out  DUR_W  last published window average of dur_dp
avg_exec  out  DUR_W  last published window average of dur_exec
max_exec  out  DUR_W  largest dur_exec in the last published window
out_valid  out  1  one-cycle pulse when a new window is published
win_count  out  16  number of windows published; wraps at 2^16
err_count  out  ERR_W  number of rejected samples; saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge) clears everything:
  - all outputs = 0;
  - internal sums, running max and sample counter = 0;
  - state = IDLE.
- Reset mid-window discards the partial window. No out_valid is generated.
- States:
  - IDLE: enable==0. dur_valid is ignored. Goes to ACCUM when enable==1.
  - ACCUM: accepts samples. When the 2^LOG2_WIN-th sample is accepted, goes to PUBLISH.
  - PUBLISH: lasts exactly one cycle, then returns to ACCUM, or to IDLE if enable==0.
- Accept rule: a sample is accepted when all of the following hold:
  - state is ACCUM or PUBLISH;
  - dur_valid==1, enable==1 and clear==0;
  - dur_dp <= dur_exec.
- A sample accepted during PUBLISH belongs to the new window.
- Reject rule: dur_valid==1 with dur_dp > dur_exec, while enabled and not cleared.
  - err_count increments and saturates at 2^ERR_W-1.
  - The sample does not count toward the window.
- Accumulators:
  - sum_dp and sum_exec are DUR_W+LOG2_WIN bits wide, so they never overflow.
  - The running max compares with unsigned >=.
- Publish timing:
  - The cycle after the last sample's accept edge, out_valid=1 for exactly one cycle.
  - avg_dp = sum_dp >> LOG2_WIN (truncate). avg_exec is computed the same way.
  - max_exec = window max. All include the final sample.
  - win_count increments by 1.
  - Sums, max and sample counter restart at 0, or at the new sample if one is accepted in the PUBLISH cycle.
- Output hold: avg_dp, avg_exec and max_exec hold their values until the next publish. clear and enable do not change them.
- clear:
  - zeroes the sums, running max and sample counter;
  - has priority over a same-cycle dur_valid, which is dropped and not counted as an error;
  - does not touch the outputs, win_count or err_count.
- enable falling during ACCUM:
  - discards the partial window, as clear does;
  - state = IDLE.

Decomposition:
- Shared avfcl_pkg:
  - DURATION_WIDTH = 10 (the sq_dur default);
  - window-size constant;
  - typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} for this block's state.
- The saturating err_count is a natural small sub-module, sat_counter, parameterised by width. It is reusable by other AVF counters.
- Everything else is inline.

Test Plan:
- Reset held low for 2 cycles, then released -> all outputs 0, no out_valid; dur_valid while enable==0 -> ignored, no accumulation.
- enable=1, 16 samples with dp=10, exec=30 -> one cycle after the 16th: out_valid=1 for 1 cycle, avg_dp=10, avg_exec=30, max_exec=30, win_count=1.
- 16 samples with dp=0, exec=0..15 ramp -> avg_exec=7 (120>>4), avg_dp=0, max_exec=15; outputs hold until the next window.
- Sample dp=50, exec=20 -> rejected: err_count=1, window count unchanged; 300 rejects -> err_count=255.
- clear asserted in the same cycle as the 16th valid sample -> no out_valid; a fresh 16 samples are then required; previous outputs persist.
- Reset low after 8 samples, then 16 samples with dp=4, exec=8 -> win_count=1, avg_dp=4, avg_exec=8 (pre-reset samples excluded); a sample in the PUBLISH cycle counts toward window 2.
